// File: rtl/xma_coef_loader_if.sv
// Host-side write bus of the crosstalk coefficient loader: coefficient writes, shadow clear
// and commit request, with back-pressure on writes.
interface xma_coef_loader_if #(
    parameter int NQDRV     = 4,
    parameter int COEFWIDTH = 32
);
    localparam int ADDRWIDTH = $clog2(NQDRV * NQDRV);

    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDRWIDTH:0]   wr_addr;
    logic [COEFWIDTH-1:0] wr_data;
    logic                 clr;
    logic                 commit_req;

    modport master (
        output wr_valid, wr_addr, wr_data, clr, commit_req,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr, commit_req,
        output wr_ready
    );
endinterface

// File: rtl/xma_coef_loader.sv
// Shadow/active coefficient matrix for the xma block: host writes the shadow copy, a commit
// copies it to the active copy on the next frame sync. Optional readback: XMA_COEF_RDBK_EN.
module xma_coef_loader #(
    parameter  int NQDRV     = 4,
    parameter  int COEFWIDTH = 32,
    localparam int ADDRWIDTH = $clog2(NQDRV * NQDRV)
) (
    input  logic                             clk,
    input  logic                             reset,
    xma_coef_loader_if.slave                 bus,
    input  logic                             sync,
    output logic                             pending,
    output logic                             commit_done,
    output logic [15:0]                      commit_cnt,
    output logic                             err_addr,
    output logic [NQDRV*NQDRV*COEFWIDTH-1:0] coef
`ifdef XMA_COEF_RDBK_EN
    ,
    input  logic [ADDRWIDTH-1:0]             rd_addr,
    input  logic                             rd_sel,
    output logic [COEFWIDTH-1:0]             rd_data
`endif
);
    localparam int                 NWORDS   = NQDRV * NQDRV;
    localparam logic [ADDRWIDTH:0] NWORDS_A = NWORDS[ADDRWIDTH:0];

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                           state_r;
    state_t                           state_nxt_s;
    logic                             copy_s;
    logic                             wr_ready_s;
    logic                             wr_fire_s;
    logic                             in_range_s;
    logic                             clr_s;
    logic [COEFWIDTH-1:0]             shadow_r [NWORDS];
    logic [NWORDS*COEFWIDTH-1:0]      active_r;
    logic                             commit_done_r;
    logic [15:0]                      commit_cnt_r;
    logic                             err_addr_r;

    assign wr_ready_s   = (state_r == ST_IDLE) & ~reset;
    assign wr_fire_s    = bus.wr_valid & wr_ready_s;
    assign in_range_s   = (bus.wr_addr < NWORDS_A);
    // The shadow is frozen while a commit is pending, so a clear is only honoured in IDLE.
    assign clr_s        = bus.clr & (state_r == ST_IDLE);
    assign bus.wr_ready = wr_ready_s;

    // Next-state logic; the copy strobe only fires on a sync seen while already pending.
    always_comb begin
        state_nxt_s = state_r;
        copy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.commit_req) begin
                    state_nxt_s = ST_PENDING;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (sync) begin
                    state_nxt_s = ST_IDLE;
                    copy_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                copy_s      = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shadow matrix: an accepted in-range write beats a same-cycle clear for its own word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                shadow_r[i] <= {COEFWIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                if (wr_fire_s && in_range_s && (bus.wr_addr[ADDRWIDTH-1:0] == ADDRWIDTH'(i))) begin
                    shadow_r[i] <= bus.wr_data;
                end else if (clr_s) begin
                    shadow_r[i] <= {COEFWIDTH{1'b0}};
                end
            end
        end
    end

    // Active matrix plus commit pulse and counter, all updated on the same copy edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r      <= {(NWORDS*COEFWIDTH){1'b0}};
            commit_done_r <= 1'b0;
            commit_cnt_r  <= 16'd0;
        end else if (copy_s) begin
            for (int i = 0; i < NWORDS; i++) begin
                active_r[i*COEFWIDTH +: COEFWIDTH] <= shadow_r[i];
            end
            commit_done_r <= 1'b1;
            commit_cnt_r  <= commit_cnt_r + 16'd1;
        end else begin
            commit_done_r <= 1'b0;
        end
    end

    // Sticky out-of-range write flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr_r <= 1'b0;
        end else if (wr_fire_s && !in_range_s) begin
            err_addr_r <= 1'b1;
        end
    end

    assign pending     = (state_r == ST_PENDING);
    assign commit_done = commit_done_r;
    assign commit_cnt  = commit_cnt_r;
    assign err_addr    = err_addr_r;
    assign coef        = active_r;

`ifdef XMA_COEF_RDBK_EN
    logic [COEFWIDTH-1:0] rd_data_r;

    // Registered readback; sampling pre-edge contents yields the old word on a write collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {COEFWIDTH{1'b0}};
        end else if ({1'b0, rd_addr} >= NWORDS_A) begin
            rd_data_r <= {COEFWIDTH{1'b0}};
        end else if (rd_sel) begin
            rd_data_r <= active_r[int'(rd_addr)*COEFWIDTH +: COEFWIDTH];
        end else begin
            rd_data_r <= shadow_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;
`endif
endmodule
